wb_arb2: RTL

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2_if.sv | 48 ++++
 rtl/wb_arb2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2_if.sv
// -----------------------------------------------------------------------------
// wb_arb2_if -- Wishbone (pipelined) bus bundle used by the wb_arb2 arbiter.
//
// One instance carries every handshake/data signal between a bus master and a
// bus slave. The master side drives the request signals and receives the
// response signals. The slave side does the opposite.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (byte selects are DATA_W/8 wide)
//
// Signals
//   cyc, stb, we      request: bus cycle, strobe, write enable
//   adr, sel, wdat    request: address, byte selects, write data
//   rdat              response: read data
//   ack, err, rty     response: acknowledge, error, retry
//   stall             response: slave cannot accept a strobe this cycle
//
// Modports
//   master  drives the request, samples the response
//   slave   samples the request, drives the response
// -----------------------------------------------------------------------------
interface wb_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W/8-1:0] sel;
    logic [DATA_W-1:0]   wdat;
    logic [DATA_W-1:0]   rdat;
    logic                ack;
    logic                err;
    logic                rty;
    logic                stall;

    modport master (
        output cyc, stb, we, adr, sel, wdat,
        input  rdat, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, wdat,
        output rdat, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_arb2.sv
// -----------------------------------------------------------------------------
// wb_arb2 -- two-master to one-slave Wishbone arbiter with bus lock.
//
// A registered FSM (IDLE / GNT0 / GNT1) owns the shared slave port. From IDLE
// a single request is granted on the next edge; two simultaneous requests are
// resolved round-robin against the last-grant register (master 0 wins the
// first tie after reset). A granted master keeps the bus for as long as it
// holds cyc, so pipelined bursts complete under one grant. Every grant is
// followed by at least one IDLE cycle.
//
// While granted, the owner's request signals drive the slave port
// combinationally and the slave's response goes to the owner only. Every
// master that does not own the bus sees stall=1 and ack/err/rty/rdat=0.
//
// Optional feature (macro WB_ARB2_TIMEOUT_EN): an 8-bit counter measures
// granted cycles without a slave response (ack/err/rty). When it reaches
// TMO_CYC the owner gets err for one cycle, the slave cycle is dropped that
// same cycle and the FSM returns to IDLE. Without the macro there is no
// counter and err passes straight through.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TMO_CYC  timeout limit in cycles (1..255), used only with the macro
//
// Ports
//   clk_i   clock, all state on the rising edge
//   rst_i   asynchronous active-high reset (forces IDLE, last grant = 1)
//   m0      master 0 bus (arbiter acts as its slave)
//   m1      master 1 bus (arbiter acts as its slave)
//   s       shared slave bus (arbiter acts as its master)
// -----------------------------------------------------------------------------
module wb_arb2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    wb_arb2_if.slave  m0,
    wb_arb2_if.slave  m1,
    wb_arb2_if.master s
);

    if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_range
        $error("wb_arb2: TMO_CYC must lie in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_lg;
    logic   w_lg_nxt;
    logic   w_req0;
    logic   w_req1;
    logic   w_tmo;

    assign w_req0 = m0.cyc & m0.stb;
    assign w_req1 = m1.cyc & m1.stb;

`ifdef WB_ARB2_TIMEOUT_EN
    localparam logic [7:0] TMO_VAL = 8'(TMO_CYC);

    logic       w_rsp;
    logic [7:0] r_tmo_cnt;

    assign w_rsp = s.ack | s.err | s.rty;

    // Counts granted cycles since grant entry or the last slave response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= 8'd0;
        end else if ((r_state == IDLE) || w_tmo || w_rsp) begin
            r_tmo_cnt <= 8'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo = (r_state != IDLE) && (r_tmo_cnt == TMO_VAL);
`else
    assign w_tmo = 1'b0;
`endif

    // Grant state and last-grant register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_lg    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_lg    <= w_lg_nxt;
        end
    end

    // Next grant: round-robin from IDLE, hold while the owner keeps cyc.
    always_comb begin
        w_state_nxt = r_state;
        w_lg_nxt    = r_lg;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    // Tie goes to the master that was not granted last.
                    if (r_lg) begin
                        w_state_nxt = GNT0;
                        w_lg_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = GNT1;
                        w_lg_nxt    = 1'b1;
                    end
                end else if (w_req0) begin
                    w_state_nxt = GNT0;
                    w_lg_nxt    = 1'b0;
                end else if (w_req1) begin
                    w_state_nxt = GNT1;
                    w_lg_nxt    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GNT0: begin
                if (!m0.cyc || w_tmo) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GNT0;
                end
            end
            GNT1: begin
                if (!m1.cyc || w_tmo) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GNT1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus steering: owner's request to the slave, slave response to the owner.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = {ADDR_W{1'b0}};
        s.sel    = {(DATA_W/8){1'b0}};
        s.wdat   = {DATA_W{1'b0}};
        m0.rdat  = {DATA_W{1'b0}};
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.rty   = 1'b0;
        m0.stall = 1'b1;
        m1.rdat  = {DATA_W{1'b0}};
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.rty   = 1'b0;
        m1.stall = 1'b1;
        case (r_state)
            GNT0: begin
                // A timeout drops the slave cycle in the same cycle as the err.
                s.cyc  = m0.cyc & ~w_tmo;
                s.stb  = m0.stb & ~w_tmo;
                s.we   = m0.we;
                s.adr  = m0.adr;
                s.sel  = m0.sel;
                s.wdat = m0.wdat;
                if (w_tmo) begin
                    m0.err = 1'b1;
                end else begin
                    m0.rdat  = s.rdat;
                    m0.ack   = s.ack;
                    m0.err   = s.err;
                    m0.rty   = s.rty;
                    m0.stall = s.stall;
                end
            end
            GNT1: begin
                s.cyc  = m1.cyc & ~w_tmo;
                s.stb  = m1.stb & ~w_tmo;
                s.we   = m1.we;
                s.adr  = m1.adr;
                s.sel  = m1.sel;
                s.wdat = m1.wdat;
                if (w_tmo) begin
                    m1.err = 1'b1;
                end else begin
                    m1.rdat  = s.rdat;
                    m1.ack   = s.ack;
                    m1.err   = s.err;
                    m1.rty   = s.rty;
                    m1.stall = s.stall;
                end
            end
            default: begin
                s.cyc = 1'b0;
            end
        endcase
    end

endmodule
